// File: rtl/ptn_seq_pkg.sv
// Shared types and constants for the pattern sequencer.
// Optional build macro: PTN_SEQ_MASK_EN (adds a pattern-enable mask to auto advance).
package ptn_seq_pkg;

    localparam int DEF_NUM_PTN = 8;
    localparam int DEF_PTN_W   = 3;
    localparam int DEF_HOLD_W  = 8;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        PEND   = 2'd2
    } seq_state_t;

    // Pattern codes understood by the downstream pattern generator
    localparam logic [DEF_PTN_W-1:0] PTN_GRAY_BAR  = 3'd0;
    localparam logic [DEF_PTN_W-1:0] PTN_BLACK     = 3'd1;
    localparam logic [DEF_PTN_W-1:0] PTN_WHITE     = 3'd2;
    localparam logic [DEF_PTN_W-1:0] PTN_COLOR_BAR = 3'd3;
    localparam logic [DEF_PTN_W-1:0] PTN_CHECKER   = 3'd4;
    localparam logic [DEF_PTN_W-1:0] PTN_RAMP      = 3'd5;
    localparam logic [DEF_PTN_W-1:0] PTN_GRID      = 3'd6;
    localparam logic [DEF_PTN_W-1:0] PTN_NOISE     = 3'd7;

endpackage

// File: rtl/ptn_next_sel.sv
// Combinational next-pattern selection for auto advance, wrapping at NUM_PTN.
// With PTN_SEQ_MASK_EN the search skips disabled patterns; o_valid=0 when none is enabled.
module ptn_next_sel
    import ptn_seq_pkg::*;
#(
    parameter int NUM_PTN = DEF_NUM_PTN,
    parameter int PTN_W   = DEF_PTN_W
) (
    input  logic [PTN_W-1:0]   i_cur,
`ifdef PTN_SEQ_MASK_EN
    input  logic [NUM_PTN-1:0] i_mask,
`endif
    output logic [PTN_W-1:0]   o_next,
    output logic               o_valid
);

`ifdef PTN_SEQ_MASK_EN
    logic [NUM_PTN-1:0] w_shift;

    // Walk offsets from farthest to nearest so the nearest enabled index wins;
    // offset NUM_PTN is the current pattern itself, so a lone enabled current stays.
    always_comb begin
        o_next  = i_cur;
        o_valid = 1'b0;
        w_shift = '0;
        for (int k = NUM_PTN; k >= 1; k--) begin
            w_shift = i_mask >> ((int'(i_cur) + k) % NUM_PTN);
            if (w_shift[0]) begin
                o_next  = PTN_W'((int'(i_cur) + k) % NUM_PTN);
                o_valid = 1'b1;
            end
        end
    end
`else
    always_comb begin
        o_valid = 1'b1;
        if (i_cur >= PTN_W'(NUM_PTN - 1)) begin
            o_next = '0;
        end else begin
            o_next = i_cur + PTN_W'(1);
        end
    end
`endif

endmodule

// File: rtl/ptn_seq_ctrl.sv
// Pattern sequencer: switches the pattern select only on VSync rising edges (auto cycle or req/ack).
// Optional build macro: PTN_SEQ_MASK_EN (adds i_ptn_mask to restrict the auto sequence).
module ptn_seq_ctrl
    import ptn_seq_pkg::*;
#(
    parameter int NUM_PTN = DEF_NUM_PTN,
    parameter int PTN_W   = DEF_PTN_W,
    parameter int HOLD_W  = DEF_HOLD_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_VSync,
    input  logic              i_auto_en,
    input  logic [HOLD_W-1:0] i_hold_frames,
    input  logic              i_req,
    input  logic [PTN_W-1:0]  i_req_ptn,
`ifdef PTN_SEQ_MASK_EN
    input  logic [NUM_PTN-1:0] i_ptn_mask,
`endif
    output logic              o_ack,
    output logic [PTN_W-1:0]  o_PTN_type,
    output logic [HOLD_W-1:0] o_frame_cnt,
    output logic              o_frame_start,
    output logic              o_busy
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              r_vs_d;
    logic              r_frame_start;
    logic              r_ack;
    logic [PTN_W-1:0]  r_ptn;
    logic [PTN_W-1:0]  r_req_ptn;
    logic [HOLD_W-1:0] r_cnt;

    logic              w_edge;
    logic              w_accept;
    logic              w_ack_nxt;
    logic [PTN_W-1:0]  w_ptn_nxt;
    logic [PTN_W-1:0]  w_req_ptn_nxt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic [HOLD_W-1:0] w_hold_last;
    logic [PTN_W-1:0]  w_next_ptn;
    logic              w_next_valid;

    ptn_next_sel #(
        .NUM_PTN (NUM_PTN),
        .PTN_W   (PTN_W)
    ) u_next_sel (
        .i_cur   (r_ptn),
`ifdef PTN_SEQ_MASK_EN
        .i_mask  (i_ptn_mask),
`endif
        .o_next  (w_next_ptn),
        .o_valid (w_next_valid)
    );

    // Registered boundary decisions land in the same cycle as o_frame_start
    assign w_edge      = i_VSync & ~r_vs_d;
    assign w_accept    = i_req & (r_state != PEND) & ~r_ack;
    assign w_hold_last = (i_hold_frames == '0) ? '0 : i_hold_frames - HOLD_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptn_nxt     = r_ptn;
        w_cnt_nxt     = r_cnt;
        w_ack_nxt     = 1'b0;
        w_req_ptn_nxt = r_req_ptn;

        if (w_edge) begin
            case (r_state)
                PEND: begin
                    if (32'(r_req_ptn) < NUM_PTN) begin
                        w_ptn_nxt = r_req_ptn;
                    end
                    w_cnt_nxt   = '0;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = i_auto_en ? AUTO : MANUAL;
                end
                AUTO: begin
                    if (!i_auto_en) begin
                        w_state_nxt = MANUAL;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= w_hold_last) begin
                        if (w_next_valid) begin
                            w_ptn_nxt = w_next_ptn;
                        end
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    if (i_auto_en) begin
                        w_state_nxt = AUTO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + HOLD_W'(1);
                    end
                end
            endcase
        end

        // A request taken on a boundary cycle still lets that boundary update run
        if (w_accept) begin
            w_req_ptn_nxt = i_req_ptn;
            w_state_nxt   = PEND;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= MANUAL;
            r_vs_d        <= 1'b0;
            r_frame_start <= 1'b0;
            r_ack         <= 1'b0;
            r_ptn         <= PTN_W'(PTN_GRAY_BAR);
            r_req_ptn     <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_vs_d        <= i_VSync;
            r_frame_start <= w_edge;
            r_ack         <= w_ack_nxt;
            r_ptn         <= w_ptn_nxt;
            r_req_ptn     <= w_req_ptn_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign o_ack         = r_ack;
    assign o_PTN_type    = r_ptn;
    assign o_frame_cnt   = r_cnt;
    assign o_frame_start = r_frame_start;
    assign o_busy        = (r_state == PEND);

endmodule
